// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) datapath: field sizes, the default
// digit width, the field polynomial and the multiplier FSM state encoding.
// No ports; imported by the multiplier, its digit sub-block and the benches.
package gf163_pkg;

    // Field degree and width of an unreduced product (top bit always 0).
    localparam int GF_M     = 163;
    localparam int GF_DW    = 2 * GF_M;

    // Default digit width and the resulting digit count of operand b.
    localparam int GF_DIGIT = 8;
    localparam int GF_NDIG  = (GF_M + GF_DIGIT - 1) / GF_DIGIT;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1, bit i is the coefficient of x^i.
    localparam logic [GF_M:0] GF_POLY = {1'b1, 155'd0, 8'b1100_1001};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/gf163_digit_mul.sv
// Combinational carry-less product of an M-bit polynomial and one DIGIT-bit digit.
// Ports: a (M bits, multiplicand), digit (DIGIT bits), p (M+DIGIT bits, a*digit over GF(2)).
// Purely combinational: no latency, no flow control.
module gf163_digit_mul
    import gf163_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int DIGIT = GF_DIGIT
) (
    input  logic [M-1:0]       a,
    input  logic [DIGIT-1:0]   digit,
    output logic [M+DIGIT-1:0] p
);

    localparam int PW = M + DIGIT;

    // XOR of shifted copies of a, one per set bit of the digit.
    always_comb begin
        p = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (digit[j]) begin
                p = p ^ (PW'(a) << j);
            end
        end
    end

endmodule

// File: rtl/gf163_digit_mul_seq.sv
// Digit-serial GF(2)[x] multiplier: d = a*b unreduced, DIGIT bits of b per cycle, MSB digit first.
// Latency: accept edge plus NDIG RUN edges; out_valid rises NDIG+1 edges counting the accept edge.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready; in_valid ignored while busy.
// Ports: clk, rst (async, active high), in_valid/in_ready/a/b operand handshake,
//        out_valid/out_ready/d result handshake (d is 2*M bits, top bit always 0).
module gf163_digit_mul_seq
    import gf163_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int DIGIT = GF_DIGIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] d
);

    localparam int NDIG = (M + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int DW   = 2 * M;
    localparam int PW   = M + DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG + 1) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [M-1:0]     a_reg;
    logic [BW-1:0]    b_reg;
    logic [DW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] b_digit;
    logic [PW-1:0]    pp;

    // Current digit of b, most significant first. The guard keeps the
    // select in range once cnt has stepped past the final digit.
    always_comb begin
        b_digit = '0;
        if (int'(cnt) < NDIG) begin
            b_digit = b_reg[(NDIG - 1 - int'(cnt)) * DIGIT +: DIGIT];
        end
    end

    gf163_digit_mul #(
        .M     (M),
        .DIGIT (DIGIT)
    ) u_digit_mul (
        .a     (a_reg),
        .digit (b_digit),
        .p     (pp)
    );

    assign last = (int'(cnt) == NDIG - 1);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                // Returning to IDLE only; a new accept needs a further edge.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg <= a;
                b_reg <= BW'(b);
                acc   <= '0;
                cnt   <= '0;
            end else if (step) begin
                // Horner step: the true product fits in DW-1 bits, so bits
                // shifted out of the top of acc are always zero.
                acc <= (acc << DIGIT) ^ DW'(pp);
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign d = acc;

endmodule
